// File: rtl/lms_dac_iq_serializer_pkg.sv
// rtl/lms_dac_iq_serializer_pkg.sv - shared constants and types for the LMS DAC I/Q serializer
//
// Purpose: constants and types shared by the serializer top, its pair FIFO and the bench.
// Ports:   none (package).
package lms_dac_iq_serializer_pkg;

  localparam int LMS_DAC_WIDTH  = 12;
  localparam bit IQSEL_I_LEVEL  = 1'b0;
  localparam int UNDERRUN_CNT_W = 16;

  // One DAC sample pair, I in the upper half: {i, q}.
  typedef struct packed {
    logic [LMS_DAC_WIDTH-1:0] i;
    logic [LMS_DAC_WIDTH-1:0] q;
  } iq_pair_t;

  // Output slot currently being produced.
  typedef enum logic {
    PH_I = 1'b0,
    PH_Q = 1'b1
  } phase_t;

endpackage

// File: rtl/lms_iq_pair_fifo.sv
// rtl/lms_iq_pair_fifo.sv - synchronous first-word-fall-through FIFO of I/Q pairs
//
// Purpose: small pair buffer; rd_data always shows the oldest entry, no write-to-read bypass.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   flush           empties the FIFO on the next edge (wins over push/pop)
//   push, wr_data   write one entry (caller guarantees not full)
//   pop             drop the head entry (caller guarantees not empty)
//   rd_data         head entry
//   level           entries currently held
//   level_next      level after this cycle's push/pop/flush
//   empty           level == 0
module lms_iq_pair_fifo #(
  parameter int DW = 24,
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  logic [DW-1:0] wr_data,
  input  logic          pop,
  output logic [DW-1:0] rd_data,
  output logic [AW:0]   level,
  output logic [AW:0]   level_next,
  output logic          empty
);
  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = wr_data;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({push, pop})
        2'b10:   level_d = level_q + (AW+1)'(1);
        2'b01:   level_d = level_q - (AW+1)'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) mem_q[k] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  assign rd_data    = mem_q[rd_ptr_q];
  assign level      = level_q;
  assign level_next = level_d;
  assign empty      = (level_q == '0);

endmodule

// File: rtl/lms_dac_iq_serializer.sv
// rtl/lms_dac_iq_serializer.sv - I/Q pair to interleaved LMS DAC word serializer
//
// Purpose: buffers I/Q pairs and emits one DAC word per clk, I then Q, with IQSEL strobe,
//          deterministic underrun fill and a saturating underrun counter.
// Ports:
//   clk, rst              sample clock, synchronous active-high reset
//   enable                run control; low flushes the FIFO and idles the DAC outputs
//   in_i, in_q, in_valid  input pair and its valid
//   in_ready              registered ready (never depends on in_valid)
//   dac_d, dac_iqsel      interleaved DAC word and IQSEL strobe
//   dac_en                registered copy of enable (TXEN)
//   underrun              one-cycle pulse per I slot that found the FIFO empty
//   underrun_count        saturating underrun counter, cleared by clear_count
//   fifo_level            pairs currently buffered
module lms_dac_iq_serializer
  import lms_dac_iq_serializer_pkg::*;
#(
  parameter int WIDTH         = LMS_DAC_WIDTH,
  parameter int FIFO_AW       = 2,
  parameter bit IQSEL_I       = IQSEL_I_LEVEL,
  parameter bit UNDERRUN_HOLD = 1'b0,
  parameter int CNT_W         = UNDERRUN_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [WIDTH-1:0] in_i,
  input  logic [WIDTH-1:0] in_q,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] dac_d,
  output logic             dac_iqsel,
  output logic             dac_en,
  output logic             underrun,
  output logic [CNT_W-1:0] underrun_count,
  input  logic             clear_count,
  output logic [FIFO_AW:0] fifo_level
);
  localparam int PW    = 2 * WIDTH;
  localparam int DEPTH = 1 << FIFO_AW;

  phase_t           phase_q, phase_d;
  logic             en_q, en_d;
  logic             rdy_q, rdy_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             sel_q, sel_d;
  logic             und_q, und_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic [PW-1:0]    last_q, last_d;

  logic             fifo_push, fifo_pop, fifo_empty;
  logic [PW-1:0]    fifo_rd, fill_pair;
  logic [FIFO_AW:0] fifo_lvl, fifo_lvl_next;

  assign fifo_push = in_valid & rdy_q;
  // Pops only in I slots so a Q word always follows its own I word.
  assign fifo_pop  = enable & (phase_q == PH_I) & ~fifo_empty;
  assign fill_pair = UNDERRUN_HOLD ? last_q : '0;

  lms_iq_pair_fifo #(
    .DW (PW),
    .AW (FIFO_AW)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .flush      (~enable),
    .push       (fifo_push),
    .wr_data    ({in_i, in_q}),
    .pop        (fifo_pop),
    .rd_data    (fifo_rd),
    .level      (fifo_lvl),
    .level_next (fifo_lvl_next),
    .empty      (fifo_empty)
  );

  // Phase FSM: state register.
  always_ff @(posedge clk) begin
    if (rst) phase_q <= PH_I;
    else     phase_q <= phase_d;
  end

  // Phase FSM: next state; idling forces the next active cycle to be an I slot.
  always_comb begin
    phase_d = PH_I;
    if (enable && phase_q == PH_I) phase_d = PH_Q;
  end

  // Phase FSM: registered outputs and datapath.
  always_comb begin
    en_d   = enable;
    d_d    = d_q;
    sel_d  = sel_q;
    und_d  = 1'b0;
    hold_d = hold_q;
    last_d = last_q;
    if (!enable) begin
      d_d   = '0;
      sel_d = ~IQSEL_I;
    end else if (phase_q == PH_I) begin
      sel_d = IQSEL_I;
      if (!fifo_empty) begin
        d_d    = fifo_rd[PW-1:WIDTH];
        hold_d = fifo_rd[WIDTH-1:0];
        last_d = fifo_rd;
      end else begin
        d_d    = fill_pair[PW-1:WIDTH];
        hold_d = fill_pair[WIDTH-1:0];
        und_d  = 1'b1;
      end
    end else begin
      d_d   = hold_q;
      sel_d = ~IQSEL_I;
    end

    rdy_d = enable & (fifo_lvl_next < (FIFO_AW+1)'(DEPTH));

    cnt_d = cnt_q;
    if (clear_count)                cnt_d = '0;
    else if (und_d && cnt_q != '1)  cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      en_q   <= 1'b0;
      rdy_q  <= 1'b0;
      d_q    <= '0;
      sel_q  <= ~IQSEL_I;
      und_q  <= 1'b0;
      cnt_q  <= '0;
      hold_q <= '0;
      last_q <= '0;
    end else begin
      en_q   <= en_d;
      rdy_q  <= rdy_d;
      d_q    <= d_d;
      sel_q  <= sel_d;
      und_q  <= und_d;
      cnt_q  <= cnt_d;
      hold_q <= hold_d;
      last_q <= last_d;
    end
  end

  assign in_ready       = rdy_q;
  assign dac_d          = d_q;
  assign dac_iqsel      = sel_q;
  assign dac_en         = en_q;
  assign underrun       = und_q;
  assign underrun_count = cnt_q;
  assign fifo_level     = fifo_lvl;

endmodule

// File: doc/lms_dac_iq_serializer.md
Name: lms_dac_iq_serializer

Overview:
- Sits between the DSP TX chain and the LMS DAC pins (TXnD/TXnIQSEL); one instance per LMS channel.
- Accepts parallel I/Q sample pairs over a valid/ready handshake and buffers them in a 4-pair FIFO.
- Emits one 12-bit word per clk in strict I,Q alternation with a matching IQSEL strobe.
- Handles underrun deterministically and counts underrun events for host status readback.

Parameters:
- WIDTH, 12, DAC word width.
- FIFO_AW, 2, log2 of FIFO depth in I/Q pairs (depth 4).
- IQSEL_I, 0, IQSEL level driven during the I word; the Q word uses ~IQSEL_I.
- UNDERRUN_HOLD, 0, underrun fill: 0 = send zero pair, 1 = repeat last transmitted pair.

Ports:
- clk  input  1  LMS sample clock; every output is registered on its rising edge.
- rst  input  1  synchronous, active-high reset.
- enable  input  1  run control; low flushes the FIFO and idles the outputs.
- in_i  input  WIDTH  I sample.
- in_q  input  WIDTH  Q sample.
- in_valid  input  1  pair valid.
- in_ready  output  1  block can accept a pair.
- dac_d  output  WIDTH  interleaved DAC word.
- dac_iqsel  output  1  IQSEL strobe.
- dac_en  output  1  TXEN; registered copy of enable.
- underrun  output  1  one-cycle pulse on each empty I slot.
- underrun_count  output  16  saturating underrun counter.
- clear_count  input  1  synchronous clear of underrun_count.
- fifo_level  output  FIFO_AW+1  pairs currently held, range 0..4.

Behaviour:
- Reset values: dac_d=0, dac_iqsel=~IQSEL_I, dac_en=0, in_ready=0, underrun=0, underrun_count=0, fifo_level=0, phase=I, last pair=0.
- Push: a pair is written when in_valid & in_ready.
- in_ready is registered: in_ready = enable_q & (level < 4, evaluated after this cycle's push/pop). It is never combinationally dependent on in_valid.
- The phase register toggles every clk while enable_q=1, with I first after enable rises.
- I slot:
  - FIFO non-empty at the start of the cycle: pop; dac_d<=pair.i; q_hold<=pair.q; last pair <= the popped pair.
  - FIFO empty: dac_d<=fill.i; q_hold<=fill.q; underrun<=1. fill = 0 when UNDERRUN_HOLD=0, otherwise the last pair.
  - dac_iqsel<=IQSEL_I in both cases.
- Q slot: dac_d<=q_hold; dac_iqsel<=~IQSEL_I; no pop.
- Pops only happen in I slots, so a Q word is never separated from its I word.
- No bypass: a pair pushed in cycle t can first be popped in cycle t+1.
- Minimum latency: pushed at t, I slot at t+1, I word on dac_d at t+2, Q word at t+3.
- Full: in_ready=0. A pop while full raises in_ready on the following cycle. Push and pop in the same cycle leave the level unchanged.
- Simultaneous push and pop on an empty FIFO: the pop sees empty, so underrun fires; the pushed pair goes out in the next I slot.
- underrun_count: +1 per underrun pulse, saturates at 0xFFFF; clear_count wins over an increment in the same cycle.
- enable=0 (sampled into enable_q):
  - Next cycle: FIFO flushed (level=0), phase=I, dac_d=0, dac_iqsel=~IQSEL_I, dac_en=0, underrun=0.
  - underrun_count and last pair are retained.
- enable falling mid-pair drops the pending Q word; the DAC sees the 0 idle word instead.
- rst mid-operation: every register returns to its reset value on the next edge, regardless of enable.
- Width: samples pass through unmodified; no rounding or sign manipulation.

Decomposition:
- Shared package constants: LMS_DAC_WIDTH=12, IQSEL_I_LEVEL=0, UNDERRUN_CNT_W=16.
- Shared package type: the I/Q pair (2*WIDTH bits, {i,q}).
- One natural sub-module: lms_iq_pair_fifo, a synchronous FWFT FIFO of pairs with a level output and a flush input.
- The phase/underrun logic stays in the top-level module.

Test Plan:
- Reset, then enable=1 with no input -> underrun pulses every other cycle, dac_d=0, dac_iqsel alternates 0/1, underrun_count increments once per pair.
- Push (0x123,0xABC) one cycle after enable -> dac_d=0x123 with iqsel=0, then 0xABC with iqsel=1, two cycles after the push.
- Burst of 6 pairs with in_valid held high -> in_ready falls when level=4; all 6 pairs emerge in order, with no loss or duplication.
- UNDERRUN_HOLD=1: send (0x7FF,0x800), then starve -> the repeated words are 0x7FF,0x800; underrun=1 on each repeat.
- Drop enable during the Q slot -> next cycle dac_d=0, dac_en=0, fifo_level=0, in_ready=0; count retained.
- Force 0x10000 underruns, then assert clear_count in the same cycle as an underrun -> count holds at 0xFFFF, then reads 0.
